// File: rtl/sdram_rr_arbiter_pkg.sv
// Shared constants and types for the four-port SDRAM round-robin arbiter.
// PORT_BASE holds the board region base for each port; bits [21:0] stay clear so the port word address can be OR-ed in.
package sdram_rr_arbiter_pkg;

  localparam int NUM_PORTS = 4;

  localparam logic [NUM_PORTS-1:0][24:0] PORT_BASE = {
    25'h0C00000,
    25'h0800000,
    25'h0400000,
    25'h0000000
  };

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

endpackage

// File: rtl/sdram_rr_arbiter_rr_pick.sv
// Round-robin picker: the first pending port after last_grant, searching +1..+4 modulo 4.
module rr_pick
  import sdram_rr_arbiter_pkg::*;
(
  input  logic [NUM_PORTS-1:0] pending,
  input  logic [1:0]           last_grant,
  output logic                 valid,
  output logic [1:0]           grant
);

  logic [1:0] idx;

  // Walk from the farthest offset down, so the nearest pending port is written last and wins.
  always_comb begin
    valid = 1'b0;
    grant = last_grant;
    idx   = last_grant;
    for (int i = NUM_PORTS; i >= 1; i--) begin
      idx = last_grant + 2'(i);
      if (pending[idx]) begin
        valid = 1'b1;
        grant = idx;
      end
    end
  end

endmodule

// File: rtl/sdram_rr_arbiter.sv
// Four-port round-robin SDRAM read arbiter with timeout reissue and abort.
//   state | meaning
//   IDLE  | no access in flight; grant the next pending port
//   WAIT  | sdr_req issued for port gnt; waiting for sdr_rdy or a timeout
module sdram_rr_arbiter
  import sdram_rr_arbiter_pkg::*;
#(
  parameter int TIMEOUT   = 255,
  parameter int MAX_RETRY = 2
)
(
  input  logic        clk,
  input  logic        reset,
  input  logic [21:0] addr_0,
  input  logic        req_0,
  output logic [31:0] data_0,
  output logic        rdy_0,
  input  logic [21:0] addr_1,
  input  logic        req_1,
  output logic [31:0] data_1,
  output logic        rdy_1,
  input  logic [21:0] addr_2,
  input  logic        req_2,
  output logic [31:0] data_2,
  output logic        rdy_2,
  input  logic [21:0] addr_3,
  input  logic        req_3,
  output logic [31:0] data_3,
  output logic        rdy_3,
  output logic        err,
  output logic        busy,
  output logic [24:0] sdr_addr,
  output logic        sdr_req,
  input  logic [31:0] sdr_data,
  input  logic        sdr_rdy
);

  state_t                      state, state_nx;
  logic [NUM_PORTS-1:0]        req_in, req_d, req_mask, req_edge;
  logic [NUM_PORTS-1:0]        pending, pending_nx, clr;
  logic [NUM_PORTS-1:0][21:0]  addr_in, addr_q;
  logic [NUM_PORTS-1:0][31:0]  data_q, data_nx;
  logic [NUM_PORTS-1:0]        rdy_q, rdy_nx;
  logic [1:0]                  last_grant, last_nx, gnt, gnt_nx, pick_grant;
  logic                        pick_valid;
  logic [7:0]                  cnt, cnt_nx, retry, retry_nx;
  logic                        sdr_req_nx, err_nx;
  logic [24:0]                 sdr_addr_nx;

  assign req_in  = {req_3, req_2, req_1, req_0};
  assign addr_in = {addr_3, addr_2, addr_1, addr_0};

  // req_mask hides a request that was already high during reset until it drops.
  assign req_edge = req_in & ~req_d & ~req_mask;

  rr_pick u_rr_pick (
    .pending    (pending),
    .last_grant (last_grant),
    .valid      (pick_valid),
    .grant      (pick_grant)
  );

  always_comb begin
    state_nx    = state;
    last_nx     = last_grant;
    gnt_nx      = gnt;
    cnt_nx      = cnt;
    retry_nx    = retry;
    sdr_req_nx  = 1'b0;
    sdr_addr_nx = sdr_addr;
    data_nx     = data_q;
    rdy_nx      = '0;
    err_nx      = 1'b0;
    clr         = '0;
    case (state)
      IDLE: begin
        if (pick_valid) begin
          gnt_nx      = pick_grant;
          sdr_addr_nx = PORT_BASE[pick_grant] | {3'b000, addr_q[pick_grant]};
          sdr_req_nx  = 1'b1;
          cnt_nx      = '0;
          retry_nx    = '0;
          state_nx    = WAIT;
        end
      end
      WAIT: begin
        if (sdr_rdy) begin
          data_nx[gnt] = sdr_data;
          rdy_nx[gnt]  = 1'b1;
          clr[gnt]     = 1'b1;
          last_nx      = gnt;
          state_nx     = IDLE;
        end else if (cnt == 8'(TIMEOUT)) begin
          if (retry < 8'(MAX_RETRY)) begin
            sdr_req_nx = 1'b1;
            cnt_nx     = '0;
            retry_nx   = retry + 8'd1;
          end else begin
            data_nx[gnt] = '0;
            rdy_nx[gnt]  = 1'b1;
            err_nx       = 1'b1;
            clr[gnt]     = 1'b1;
            last_nx      = gnt;
            state_nx     = IDLE;
          end
        end else begin
          cnt_nx = cnt + 8'd1;
        end
      end
      default: state_nx = IDLE;
    endcase
    // A new edge on the completing port re-arms it rather than being lost.
    pending_nx = (pending & ~clr) | req_edge;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      pending    <= '0;
      last_grant <= 2'd3;
      gnt        <= '0;
      req_d      <= '0;
      req_mask   <= req_in;
      addr_q     <= '0;
      cnt        <= '0;
      retry      <= '0;
      sdr_req    <= 1'b0;
      sdr_addr   <= '0;
      data_q     <= '0;
      rdy_q      <= '0;
      err        <= 1'b0;
    end else begin
      state      <= state_nx;
      pending    <= pending_nx;
      last_grant <= last_nx;
      gnt        <= gnt_nx;
      req_d      <= req_in;
      req_mask   <= req_mask & req_in;
      cnt        <= cnt_nx;
      retry      <= retry_nx;
      sdr_req    <= sdr_req_nx;
      sdr_addr   <= sdr_addr_nx;
      data_q     <= data_nx;
      rdy_q      <= rdy_nx;
      err        <= err_nx;
      for (int n = 0; n < NUM_PORTS; n++) begin
        if (req_edge[n] && (!pending[n] || clr[n])) addr_q[n] <= addr_in[n];
      end
    end
  end

  assign busy   = (state == WAIT);
  assign data_0 = data_q[0];
  assign data_1 = data_q[1];
  assign data_2 = data_q[2];
  assign data_3 = data_q[3];
  assign rdy_0  = rdy_q[0];
  assign rdy_1  = rdy_q[1];
  assign rdy_2  = rdy_q[2];
  assign rdy_3  = rdy_q[3];

endmodule

// File: tb/tb_sdram_rr_arbiter.sv
// Directed bench for sdram_rr_arbiter (TIMEOUT=16, MAX_RETRY=2).
module tb_sdram_rr_arbiter;

  localparam logic [24:0] B0 = 25'h0000000;
  localparam logic [24:0] B1 = 25'h0400000;
  localparam logic [24:0] B2 = 25'h0800000;
  localparam logic [24:0] B3 = 25'h0C00000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [21:0] addr_0 = '0, addr_1 = '0, addr_2 = '0, addr_3 = '0;
  logic        req_0 = 1'b0, req_1 = 1'b0, req_2 = 1'b0, req_3 = 1'b0;
  logic [31:0] data_0, data_1, data_2, data_3;
  logic        rdy_0, rdy_1, rdy_2, rdy_3;
  logic        err, busy, sdr_req;
  logic [24:0] sdr_addr;
  logic [31:0] sdr_data = '0;
  logic        sdr_rdy = 1'b0;
  logic [3:0]  rdy_vec;

  int checks = 0, errors = 0;
  int cyc = 0, req_pulses = 0, mon_bad = 0;
  int req_cyc = 0, rdy_cyc = 0, c1 = 0, p0 = 0;
  logic prev_req = 1'b0;

  always #5 clk = ~clk;

  sdram_rr_arbiter #(.TIMEOUT(16), .MAX_RETRY(2)) dut (
    .clk(clk), .reset(reset),
    .addr_0(addr_0), .req_0(req_0), .data_0(data_0), .rdy_0(rdy_0),
    .addr_1(addr_1), .req_1(req_1), .data_1(data_1), .rdy_1(rdy_1),
    .addr_2(addr_2), .req_2(req_2), .data_2(data_2), .rdy_2(rdy_2),
    .addr_3(addr_3), .req_3(req_3), .data_3(data_3), .rdy_3(rdy_3),
    .err(err), .busy(busy), .sdr_addr(sdr_addr), .sdr_req(sdr_req),
    .sdr_data(sdr_data), .sdr_rdy(sdr_rdy)
  );

  assign rdy_vec = {rdy_3, rdy_2, rdy_1, rdy_0};

  always @(posedge clk) cyc <= cyc + 1;

  // Protocol watcher: single-cycle sdr_req, one-hot rdy, err only with rdy.
  always @(negedge clk) begin
    if (sdr_req) req_pulses++;
    if (sdr_req && prev_req) mon_bad++;
    if ($countones(rdy_vec) > 1) mon_bad++;
    if (err && rdy_vec == 4'b0000) mon_bad++;
    prev_req = sdr_req;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: observed no finish, expected finish before 300000 ns");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] data_of(input int p);
    case (p)
      0: return data_0;
      1: return data_1;
      2: return data_2;
      default: return data_3;
    endcase
  endfunction

  task automatic wait_req(input int max_cyc);
    logic found;
    found = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      tick(1);
      if (sdr_req) begin
        found = 1'b1;
        break;
      end
    end
    req_cyc = cyc;
    check("sdr_req_seen", 32'(found), 32'd1);
  endtask

  task automatic wait_rdy(input int max_cyc);
    logic found;
    found = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      tick(1);
      if (rdy_vec != 4'b0000) begin
        found = 1'b1;
        break;
      end
    end
    rdy_cyc = cyc;
    check("rdy_seen", 32'(found), 32'd1);
  endtask

  task automatic serve(input int p, input logic [24:0] exp_addr, input logic [31:0] d);
    wait_req(40);
    check("grant_addr", 32'(sdr_addr), 32'(exp_addr));
    tick(2);
    sdr_data = d;
    sdr_rdy  = 1'b1;
    tick(1);
    sdr_rdy  = 1'b0;
    check("grant_rdy", 32'(rdy_vec), 32'd1 << p);
    check("grant_data", data_of(p), d);
    check("grant_err", 32'(err), 32'd0);
  endtask

  initial begin
    // reset state
    tick(3);
    check("rst_sdr_req", 32'(sdr_req), 32'd0);
    check("rst_sdr_addr", 32'(sdr_addr), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rdy", 32'(rdy_vec), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_data0", data_0, 32'd0);
    reset = 1'b0;

    // single access, minimum latency
    addr_0 = 22'h000100;
    req_0  = 1'b1;
    tick(2);
    check("single_req", 32'(sdr_req), 32'd1);
    check("single_addr", 32'(sdr_addr), 32'(B0 | 25'h100));
    check("single_busy", 32'(busy), 32'd1);
    req_0 = 1'b0;
    tick(1);
    check("single_req_width", 32'(sdr_req), 32'd0);
    tick(4);
    sdr_data = 32'hCAFEF00D;
    sdr_rdy  = 1'b1;
    tick(1);
    sdr_rdy  = 1'b0;
    check("single_rdy", 32'(rdy_vec), 32'h1);
    check("single_data", data_0, 32'hCAFEF00D);
    check("single_err", 32'(err), 32'd0);
    check("single_idle", 32'(busy), 32'd0);
    tick(1);
    check("single_rdy_pulse", 32'(rdy_vec), 32'd0);
    check("single_data_hold", data_0, 32'hCAFEF00D);

    // sdr_rdy in IDLE is ignored
    sdr_data = 32'h12345678;
    sdr_rdy  = 1'b1;
    tick(1);
    sdr_rdy  = 1'b0;
    check("idle_rdy_ignored", 32'(rdy_vec), 32'd0);
    check("idle_data_hold", data_0, 32'hCAFEF00D);
    check("idle_busy", 32'(busy), 32'd0);

    // fairness: all four at once, port 0 re-requests after its completion
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    addr_0 = 22'h10; addr_1 = 22'h11; addr_2 = 22'h12; addr_3 = 22'h13;
    req_0 = 1'b1; req_1 = 1'b1; req_2 = 1'b1; req_3 = 1'b1;
    tick(1);
    req_0 = 1'b0; req_1 = 1'b0; req_2 = 1'b0; req_3 = 1'b0;
    serve(0, B0 | 25'h10, 32'hA0A00000);
    addr_0 = 22'h20;
    req_0  = 1'b1;
    serve(1, B1 | 25'h11, 32'hA1A10001);
    req_0 = 1'b0;
    serve(2, B2 | 25'h12, 32'hA2A20002);
    serve(3, B3 | 25'h13, 32'hA3A30003);
    serve(0, B0 | 25'h20, 32'hA0A00004);

    // timeout with one reissue on port 2
    p0 = req_pulses;
    addr_2 = 22'h2ABCD;
    req_2  = 1'b1;
    tick(1);
    req_2 = 1'b0;
    wait_req(10);
    c1 = req_cyc;
    check("retry_addr1", 32'(sdr_addr), 32'(B2 | 25'h2ABCD));
    wait_req(40);
    check("retry_gap", 32'(req_cyc - c1), 32'd17);
    check("retry_addr2", 32'(sdr_addr), 32'(B2 | 25'h2ABCD));
    tick(3);
    sdr_data = 32'h5EED0002;
    sdr_rdy  = 1'b1;
    tick(1);
    sdr_rdy  = 1'b0;
    check("retry_rdy", 32'(rdy_vec), 32'h4);
    check("retry_data", data_2, 32'h5EED0002);
    check("retry_err", 32'(err), 32'd0);
    check("retry_pulses", 32'(req_pulses - p0), 32'd2);

    // abort on port 3 after MAX_RETRY reissues
    p0 = req_pulses;
    addr_3 = 22'h3FFFFF;
    req_3  = 1'b1;
    tick(1);
    req_3 = 1'b0;
    wait_req(10);
    check("abort_addr", 32'(sdr_addr), 32'h0FFFFFF);
    wait_req(40);
    wait_req(40);
    c1 = req_cyc;
    wait_rdy(40);
    check("abort_gap", 32'(rdy_cyc - c1), 32'd17);
    check("abort_rdy", 32'(rdy_vec), 32'h8);
    check("abort_err", 32'(err), 32'd1);
    check("abort_data", data_3, 32'd0);
    check("abort_idle", 32'(busy), 32'd0);
    tick(3);
    check("abort_err_pulse", 32'(err), 32'd0);
    check("abort_pulses", 32'(req_pulses - p0), 32'd3);

    // duplicate edge while pending keeps the first address
    addr_0 = 22'h00ABC;
    req_0  = 1'b1;
    tick(1);
    req_0  = 1'b0;
    addr_1 = 22'h111;
    req_1  = 1'b1;
    tick(1);
    check("dup_req0", 32'(sdr_req), 32'd1);
    check("dup_addr0", 32'(sdr_addr), 32'(B0 | 25'hABC));
    req_1 = 1'b0;
    tick(1);
    addr_1 = 22'h222;
    req_1  = 1'b1;
    tick(1);
    req_1    = 1'b0;
    sdr_data = 32'h0DD00000;
    sdr_rdy  = 1'b1;
    tick(1);
    sdr_rdy  = 1'b0;
    check("dup_rdy0", 32'(rdy_vec), 32'h1);
    serve(1, B1 | 25'h111, 32'h0DD00001);

    // reset mid-WAIT, req_3 held high through reset release, stray sdr_rdy
    addr_2 = 22'h0222;
    req_2  = 1'b1;
    tick(1);
    req_2 = 1'b0;
    wait_req(10);
    tick(2);
    req_3 = 1'b1;
    tick(1);
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    p0 = req_pulses;
    sdr_data = 32'hBADBAD00;
    sdr_rdy  = 1'b1;
    tick(1);
    sdr_rdy  = 1'b0;
    check("rstwait_rdy", 32'(rdy_vec), 32'd0);
    check("rstwait_busy", 32'(busy), 32'd0);
    check("rstwait_data2", data_2, 32'd0);
    check("rstwait_addr", 32'(sdr_addr), 32'd0);
    tick(4);
    check("held_req_no_edge", 32'(req_pulses - p0), 32'd0);
    check("held_req_busy", 32'(busy), 32'd0);
    req_3 = 1'b0;
    tick(1);
    addr_3 = 22'h33;
    req_3  = 1'b1;
    tick(1);
    req_3 = 1'b0;
    serve(3, B3 | 25'h33, 32'h33330003);

    // new edge coincident with completion re-arms the same port
    addr_1 = 22'h0AAAA;
    req_1  = 1'b1;
    tick(1);
    req_1 = 1'b0;
    wait_req(10);
    check("coinc_addr1", 32'(sdr_addr), 32'(B1 | 25'h0AAAA));
    tick(1);
    sdr_data = 32'hC0C00001;
    sdr_rdy  = 1'b1;
    addr_1   = 22'h0BBBB;
    req_1    = 1'b1;
    tick(1);
    sdr_rdy = 1'b0;
    req_1   = 1'b0;
    check("coinc_rdy", 32'(rdy_vec), 32'h2);
    check("coinc_data", data_1, 32'hC0C00001);
    serve(1, B1 | 25'h0BBBB, 32'hC0C00002);

    tick(2);
    check("protocol_watch", 32'(mon_bad), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
